// File: rtl/apb_cfg_responder_pkg.sv
// Shared types and constants for the APB configuration responder and its register file.
package apb_cfg_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam int unsigned REG_ID     = 0;
  localparam int unsigned REG_STATUS = 1;

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'hC0DD_0001;

  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_cfg_regfile.sv
// Register bank for the APB responder: read-only ID word, W1C status word with hardware set,
// plain R/W words, byte-strobe merge and the read mux.
module apb_cfg_regfile
  import apb_cfg_responder_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0]   ID_VALUE   = DATA_WIDTH'(DEFAULT_ID_VALUE),
  parameter int unsigned             IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en_i,
  input  logic [IDX_W-1:0]               wr_idx_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb_i,
  input  logic [DATA_WIDTH-1:0]          sts_set_i,
  input  logic [IDX_W-1:0]               rd_idx_i,
  output logic [DATA_WIDTH-1:0]          rd_data_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] wr_mask;

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      wr_mask[8*b +: 8] = {8{wr_strb_i[b]}};
    end
  end

  // NOTE: every always_comb output gets a default before any conditional update so no latch is inferred.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (i == int'(REG_STATUS)) begin
        // Set is OR-ed in after the clear so a same-cycle hardware set wins.
        regs_d[i] = (regs_q[i] & ~((wr_en_i && wr_idx_i == IDX_W'(i)) ? (wr_data_i & wr_mask) : '0))
                    | sts_set_i;
      end else if (wr_en_i && wr_idx_i == IDX_W'(i)) begin
        regs_d[i] = (regs_q[i] & ~wr_mask) | (wr_data_i & wr_mask);
      end
    end
  end

  // NOTE: this bank is flop-based and downstream logic consumes it directly, so every word is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (rd_idx_i == IDX_W'(REG_ID)) begin
      rd_data_o = ID_VALUE;
    end else if (int'(rd_idx_i) < int'(NUM_REGS)) begin
      rd_data_o = regs_q[rd_idx_i];
    end
  end

  always_comb begin
    regs_o = '0;
    regs_o[DATA_WIDTH-1:0] = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

endmodule

// File: rtl/apb_cfg_responder.sv
// APB3 completer with programmable wait states, address error decode and a flat register image.
// Build option: define APB_PSTRB_EN to add the apb_pstrb byte-strobe input.
module apb_cfg_responder
  import apb_cfg_responder_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 20,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(DEFAULT_ID_VALUE)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          apb_paddr,
  input  logic                           apb_psel,
  input  logic                           apb_penable,
  input  logic                           apb_pwrite,
  input  logic [DATA_WIDTH-1:0]          apb_pwdata,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]        apb_pstrb,
`endif
  output logic [DATA_WIDTH-1:0]          apb_prdata,
  output logic                           apb_pready,
  output logic                           apb_pslverr,
  input  logic [DATA_WIDTH-1:0]          sts_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_regs
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  state_e                  state_q;
  logic [WAIT_CNT_W-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic                    pready_q;
  logic                    pslverr_q;
  logic [DATA_WIDTH-1:0]   prdata_q;

  logic [ADDR_WIDTH-1:0]   dec_addr;
  logic [ADDR_WIDTH-1:0]   offset;
  logic                    below_base;
  logic                    dec_err;
  logic [IDX_W-1:0]        dec_idx;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    wr_en;

  // With zero wait states the response is registered on the SETUP edge, so decode the live address there.
  always_comb begin
    dec_addr             = (state_q == IDLE) ? apb_paddr : addr_q;
    {below_base, offset} = {1'b0, dec_addr} - {1'b0, BASE_ADDR};
    dec_err              = (dec_addr[1:0] != 2'b00) || below_base
                           || ((offset >> 2) >= ADDR_WIDTH'(NUM_REGS));
    dec_idx              = offset[IDX_W+1:2];
  end

  assign wr_en = (state_q == DONE) && write_q && !pslverr_q;

`ifdef APB_PSTRB_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strb_q <= '0;
    end else if (state_q == IDLE && apb_psel && !apb_penable) begin
      strb_q <= apb_pstrb;
    end
  end
`else
  assign strb_q = '1;
`endif

  // The counter holds the remaining low-pready ACCESS cycles, so pready rises in cycle T+1+WAIT_STATES.
  // NOTE: state and registered outputs use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (apb_psel && !apb_penable) begin
            addr_q  <= apb_paddr;
            write_q <= apb_pwrite;
            wdata_q <= apb_pwdata;
            if (WAIT_STATES == 0) begin
              pready_q  <= 1'b1;
              pslverr_q <= dec_err;
              prdata_q  <= dec_err ? '0 : rd_data;
              state_q   <= DONE;
            end else begin
              cnt_q   <= WAIT_CNT_W'(WAIT_STATES);
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!apb_psel) begin
            state_q <= IDLE;
          end else if (cnt_q == WAIT_CNT_W'(1)) begin
            pready_q  <= 1'b1;
            pslverr_q <= dec_err;
            prdata_q  <= dec_err ? '0 : rd_data;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q - WAIT_CNT_W'(1);
          end
        end
        DONE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  apb_cfg_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ID_VALUE   (ID_VALUE),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_idx_i  (dec_idx),
    .wr_data_i (wdata_q),
    .wr_strb_i (strb_q),
    .sts_set_i (sts_set),
    .rd_idx_i  (dec_idx),
    .rd_data_o (rd_data),
    .regs_o    (cfg_regs)
  );

  assign apb_pready  = pready_q;
  assign apb_pslverr = pslverr_q;
  assign apb_prdata  = prdata_q;

endmodule

// File: tb/tb_apb_cfg_responder.sv
// Directed bench for apb_cfg_responder: instance 0 uses one wait state, instance 1 uses none.
module tb_apb_cfg_responder;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam logic [DW-1:0] ID = 32'hC0DD_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]             psel, penable, pwrite;
  logic [1:0][AW-1:0]     paddr;
  logic [1:0][DW-1:0]     pwdata, sts_set;
`ifdef APB_PSTRB_EN
  logic [1:0][DW/8-1:0]   pstrb;
`endif
  wire  [1:0][DW-1:0]     prdata;
  wire  [1:0]             pready, pslverr;
  wire  [1:0][NR*DW-1:0]  cfg;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [NR];
  logic [DW-1:0] rd;
  logic          er;
  int            lat;

  always #5 clk = ~clk;

  apb_cfg_responder #(.WAIT_STATES(1)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .apb_paddr   (paddr[0]),
    .apb_psel    (psel[0]),
    .apb_penable (penable[0]),
    .apb_pwrite  (pwrite[0]),
    .apb_pwdata  (pwdata[0]),
`ifdef APB_PSTRB_EN
    .apb_pstrb   (pstrb[0]),
`endif
    .apb_prdata  (prdata[0]),
    .apb_pready  (pready[0]),
    .apb_pslverr (pslverr[0]),
    .sts_set     (sts_set[0]),
    .cfg_regs    (cfg[0])
  );

  apb_cfg_responder #(.WAIT_STATES(0)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .apb_paddr   (paddr[1]),
    .apb_psel    (psel[1]),
    .apb_penable (penable[1]),
    .apb_pwrite  (pwrite[1]),
    .apb_pwdata  (pwdata[1]),
`ifdef APB_PSTRB_EN
    .apb_pstrb   (pstrb[1]),
`endif
    .apb_prdata  (prdata[1]),
    .apb_pready  (pready[1]),
    .apb_pslverr (pslverr[1]),
    .sts_set     (sts_set[1]),
    .cfg_regs    (cfg[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle; SETUP is driven at once, and the task returns mid-cycle right after DONE.
  task automatic xfer(input int d, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [DW-1:0] done_sts,
                      output logic [DW-1:0] rdv, output logic erv, output int latv);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = a;
    pwdata[d]  = wd;
    latv = 0;
    do begin
      @(negedge clk);
      penable[d] = 1'b1;
      latv++;
    end while (!pready[d] && latv < 20);
    rdv        = prdata[d];
    erv        = pslverr[d];
    sts_set[d] = done_sts;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    @(negedge clk);
    sts_set[d] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0; sts_set = '0;
`ifdef APB_PSTRB_EN
    pstrb = '1;
`endif
    repeat (3) @(negedge clk);

    check("rst_pready", 64'(pready[0]), 0);
    check("rst_pslverr", 64'(pslverr[0]), 0);
    check("rst_prdata", 64'(prdata[0]), 0);
    check("rst_cfg_id", 64'(cfg[0][DW-1:0]), 64'(ID));
    check("rst_cfg_rest_zero", 64'(cfg[0][NR*DW-1:DW] == '0), 1);
    rst = 1'b0;
    @(negedge clk);

    // ID read with one wait state
    xfer(0, 1'b0, 'h0, '0, '0, rd, er, lat);
    check("id_latency", 64'(lat), 2);
    check("id_rdata", 64'(rd), 64'(ID));
    check("id_pslverr", 64'(er), 0);
    check("pready_one_cycle", 64'(pready[0]), 0);

    // Plain R/W register
    xfer(0, 1'b1, 'h8, 32'hA5A5_5A5A, '0, rd, er, lat);
    check("wr8_pslverr", 64'(er), 0);
    check("wr8_cfg_word2", 64'(cfg[0][2*DW +: DW]), 64'h0000_0000_A5A5_5A5A);
    xfer(0, 1'b0, 'h8, '0, '0, rd, er, lat);
    check("rd8_rdata", 64'(rd), 64'hA5A5_5A5A);

    // Error decode
    xfer(0, 1'b1, 'h42, 32'hFFFF_FFFF, '0, rd, er, lat);
    check("wr42_pslverr", 64'(er), 1);
    check("wr42_latency", 64'(lat), 2);
    xfer(0, 1'b1, 'h9, 32'hFFFF_FFFF, '0, rd, er, lat);
    check("wr9_pslverr", 64'(er), 1);
    check("err_no_change_word2", 64'(cfg[0][2*DW +: DW]), 64'h0000_0000_A5A5_5A5A);
    xfer(0, 1'b0, 'h40, '0, '0, rd, er, lat);
    check("rd40_pslverr", 64'(er), 1);
    check("rd40_rdata", 64'(rd), 0);
    xfer(0, 1'b0, 'hA, '0, '0, rd, er, lat);
    check("rdA_pslverr", 64'(er), 1);
    check("rdA_rdata", 64'(rd), 0);
    xfer(0, 1'b0, 'h3C, '0, '0, rd, er, lat);
    check("rd3C_pslverr", 64'(er), 0);

    // Register 0 is read-only
    xfer(0, 1'b1, 'h0, 32'h1234_5678, '0, rd, er, lat);
    check("wr0_pslverr", 64'(er), 0);
    xfer(0, 1'b0, 'h0, '0, '0, rd, er, lat);
    check("wr0_id_kept", 64'(rd), 64'(ID));

    // Status W1C with hardware set
    sts_set[0] = 32'h5;
    @(negedge clk);
    sts_set[0] = '0;
    check("sts_set_cfg", 64'(cfg[0][DW +: DW]), 5);
    xfer(0, 1'b1, 'h4, 32'h1, 32'h1, rd, er, lat);
    xfer(0, 1'b0, 'h4, '0, '0, rd, er, lat);
    check("sts_set_wins", 64'(rd), 5);
    xfer(0, 1'b1, 'h4, 32'h4, '0, rd, er, lat);
    xfer(0, 1'b0, 'h4, '0, 32'h8, rd, er, lat);
    check("sts_w1c_read", 64'(rd), 1);
    check("sts_done_set_after", 64'(cfg[0][DW +: DW]), 9);

    // Abort during ACCESS
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 'hC; pwdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    check("abort_pready_a", 64'(pready[0]), 0);
    @(negedge clk);
    check("abort_pready_b", 64'(pready[0]), 0);
    check("abort_no_write", 64'(cfg[0][3*DW +: DW]), 0);
    xfer(0, 1'b0, 'hC, '0, '0, rd, er, lat);
    check("after_abort_latency", 64'(lat), 2);
    check("after_abort_rdata", 64'(rd), 0);

    // penable high while idle is ignored
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 'hC; pwdata[0] = 32'h1;
    repeat (3) @(negedge clk);
    check("penable_idle_pready", 64'(pready[0]), 0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    check("penable_idle_no_write", 64'(cfg[0][3*DW +: DW]), 0);

    // Reset while the response is on the bus
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 'h8; pwdata[0] = 32'h1111_1111;
    @(negedge clk);
    penable[0] = 1'b1;
    @(negedge clk);
    check("pre_rst_pready", 64'(pready[0]), 1);
    rst = 1'b1;
    #1;
    check("rst_async_pready", 64'(pready[0]), 0);
    check("rst_async_regs", 64'(cfg[0][NR*DW-1:DW] == '0), 1);
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    xfer(0, 1'b0, 'h4, '0, '0, rd, er, lat);
    check("post_rst_reg1", 64'(rd), 0);
    xfer(0, 1'b0, 'h8, '0, '0, rd, er, lat);
    check("post_rst_reg2", 64'(rd), 0);

`ifdef APB_PSTRB_EN
    pstrb[0] = 4'h2;
    xfer(0, 1'b1, 'h14, 32'hFFFF_FFFF, '0, rd, er, lat);
    pstrb[0] = '1;
    check("pstrb_byte1_only", 64'(cfg[0][5*DW +: DW]), 64'h0000_0000_0000_FF00);
`endif

    // Back-to-back random traffic against a reference model, zero wait states
    model[0] = ID;
    for (int i = 1; i < NR; i++) model[i] = '0;
    for (int n = 0; n < 100; n++) begin
      int unsigned   idx;
      logic          mis, w, exp_err;
      logic [AW-1:0] a;
      logic [DW-1:0] wd, exp_rd;
      idx = $urandom_range(0, NR + 1);
      mis = ($urandom_range(0, 7) == 0);
      a   = AW'(idx * 4 + (mis ? $urandom_range(1, 3) : 0));
      w   = 1'($urandom_range(0, 1));
      wd  = $urandom;
      exp_err = mis || (idx >= NR);
      exp_rd  = '0;
      if (!exp_err) exp_rd = model[idx];
      xfer(1, w, a, wd, '0, rd, er, lat);
      check($sformatf("stress%0d_latency", n), 64'(lat), 1);
      check($sformatf("stress%0d_pslverr", n), 64'(er), 64'(exp_err));
      if (!w) begin
        check($sformatf("stress%0d_rdata", n), 64'(rd), 64'(exp_rd));
      end else if (!exp_err) begin
        if (idx == 1) model[1] = model[1] & ~wd;
        else if (idx >= 2) model[idx] = wd;
      end
    end
    for (int i = 0; i < NR; i++) begin
      check($sformatf("stress_cfg_word%0d", i), 64'(cfg[1][i*DW +: DW]), 64'(model[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
